// File: rtl/fir_ctrl_pkg.sv
// Shared types, default parameters and helpers for the FIR coefficient
// sequencing front-end.
package fir_ctrl_pkg;

    localparam int CLK_DIV_DEF   = 20;
    localparam int ADDR_W_DEF    = 6;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_COEFF_DEF = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        TAIL = 2'd3
    } ctrlState_e;

    // A tap count is usable only if it is non-zero and fits the coefficient RAM.
    function automatic logic isLegalCount(input int num, input int maxCoeff);
        return (num >= 1) && (num <= maxCoeff);
    endfunction

endpackage

// File: rtl/fir_sample_strobe_gen.sv
// Free-running clock divider producing the one-cycle FIR sample strobe;
// strobes that land while iGate is high are dropped, never deferred.
module fir_sample_strobe_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic iClk12M,
    input  logic iRsn,
    input  logic iGate,
    output logic oEnSample600k
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] divCntReg;

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            divCntReg     <= '0;
            oEnSample600k <= 1'b0;
        end else begin
            oEnSample600k <= (divCntReg == CNT_LAST) && !iGate;
            divCntReg     <= (divCntReg == CNT_LAST) ? '0 : divCntReg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fir_coeff_seq_ctrl.sv
// Coefficient-load sequencer for the FIR: streams host words into the
// coefficient RAM and gates the 600 kHz sample strobe during updates.
module fir_coeff_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_COEFF = MAX_COEFF_DEF
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iUpdReq,
    input  logic [ADDR_W-1:0] iUpdNum,
    input  logic              iUpdAbort,
    input  logic              iCoefValid,
    input  logic [DATA_W-1:0] iCoefData,
    output logic              oCoefReady,
    output logic              oEnSample600k,
    output logic              oCoeffUpdateFlag,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWrDtRam,
    output logic [ADDR_W-1:0] oNumOfCoeff,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    ctrlState_e        stateReg, stateNext;
    logic [ADDR_W-1:0] addrCntReg, addrCntNext;
    logic [ADDR_W-1:0] numReqReg, numReqNext;
    logic              wrEn;
    logic              doneNext;
    logic              errNext;

    // Flag is decoded straight from the state register so an async reset drops it at once.
    assign oCoeffUpdateFlag = (stateReg != IDLE);
    assign oBusy            = (stateReg != IDLE);
    assign oCoefReady       = (stateReg == LOAD);

    always_comb begin
        stateNext   = stateReg;
        addrCntNext = addrCntReg;
        numReqNext  = numReqReg;
        wrEn        = 1'b0;
        doneNext    = 1'b0;
        errNext     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (iUpdReq) begin
                    if (isLegalCount(int'(iUpdNum), MAX_COEFF)) begin
                        numReqNext  = iUpdNum;
                        addrCntNext = '0;
                        stateNext   = LOAD;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Abort takes priority over a word offered in the same cycle.
                if (iUpdAbort) begin
                    errNext   = 1'b1;
                    stateNext = IDLE;
                end else if (iCoefValid) begin
                    wrEn      = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (iUpdAbort) begin
                    errNext   = 1'b1;
                    stateNext = IDLE;
                end else if (addrCntReg == numReqReg - ADDR_W'(1)) begin
                    stateNext = TAIL;
                end else begin
                    addrCntNext = addrCntReg + ADDR_W'(1);
                    stateNext   = LOAD;
                end
            end
            TAIL: begin
                doneNext  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            stateReg    <= IDLE;
            addrCntReg  <= '0;
            numReqReg   <= '0;
            oAddrRam    <= '0;
            oWrDtRam    <= '0;
            oNumOfCoeff <= ADDR_W'(MAX_COEFF);
            oDone       <= 1'b0;
            oErr        <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            addrCntReg <= addrCntNext;
            numReqReg  <= numReqNext;
            oDone      <= doneNext;
            oErr       <= errNext;
            if (wrEn) begin
                oAddrRam <= addrCntReg;
                oWrDtRam <= iCoefData;
            end
            if (doneNext) begin
                oNumOfCoeff <= numReqReg;
            end
        end
    end

    fir_sample_strobe_gen #(
        .CLK_DIV(CLK_DIV)
    ) uStrobeGen (
        .iClk12M      (iClk12M),
        .iRsn         (iRsn),
        .iGate        (oCoeffUpdateFlag),
        .oEnSample600k(oEnSample600k)
    );

endmodule

// File: doc/fir_coeff_seq_ctrl.md
Name: fir_coeff_seq_ctrl

Overview:
Control front-end for the FIR datapath (DUT_top), clocked at 12 MHz. Generates the 600 kHz sample strobe by dividing the clock. Sequences coefficient-RAM loads from a host valid/ready stream onto the FIR's iCoeffUpdateFlag/iAddrRam/iWrDtRam/iNumOfCoeff inputs. Suppresses sample strobes while a coefficient update is in progress.

Parameters:
CLK_DIV, 20, clock cycles per sample strobe (12 MHz / 20 = 600 kHz)
ADDR_W, 6, coefficient RAM address width
DATA_W, 16, coefficient word width
MAX_COEFF, 40, maximum legal tap count; also the reset value of oNumOfCoeff

Ports:
iClk12M  in  1  system clock, 12 MHz
iRsn  in  1  reset, asynchronous, active-low
iUpdReq  in  1  start-update pulse; sampled only in IDLE
iUpdNum  in  ADDR_W  requested tap count for this update
iUpdAbort  in  1  abort the update in progress
iCoefValid  in  1  host coefficient word valid
iCoefData  in  DATA_W  host coefficient word
oCoefReady  out  1  controller accepts a coefficient this cycle
oEnSample600k  out  1  one-cycle sample strobe to the FIR
oCoeffUpdateFlag  out  1  FIR coefficient-update mode
oAddrRam  out  ADDR_W  coefficient RAM address
oWrDtRam  out  DATA_W  coefficient RAM write data
oNumOfCoeff  out  ADDR_W  committed tap count
oBusy  out  1  high in any state other than IDLE
oDone  out  1  one-cycle pulse when an update commits
oErr  out  1  one-cycle pulse on a rejected request or an abort

Behaviour:
- Reset values (async, iRsn=0): all outputs 0 except oNumOfCoeff=MAX_COEFF. The divider counter and FSM go to 0 / IDLE.
- Strobe divider:
  - Free-running counter 0..CLK_DIV-1, wraps to 0. It never stops, including during updates.
  - oEnSample600k is registered. It is high for exactly one cycle when the counter is CLK_DIV-1 and oCoeffUpdateFlag is 0.
  - The first strobe occurs CLK_DIV cycles after reset release.
  - A strobe that falls while the flag is high is dropped, not deferred. The strobe period is therefore always a multiple of CLK_DIV.
- FSM states: IDLE, LOAD, HOLD, TAIL.
- IDLE:
  - oCoeffUpdateFlag=0, oCoefReady=0.
  - On iUpdReq with 1 <= iUpdNum <= MAX_COEFF: latch N=iUpdNum, set addr counter to 0, go to LOAD.
  - On iUpdReq with iUpdNum=0 or iUpdNum>MAX_COEFF: pulse oErr for one cycle, stay in IDLE.
- LOAD:
  - oCoeffUpdateFlag=1, oCoefReady=1.
  - On iCoefValid&&oCoefReady: register oAddrRam<=addr and oWrDtRam<=iCoefData, go to HOLD.
  - With no valid, wait indefinitely; there is no timeout.
- HOLD:
  - oCoefReady=0. Address and data stay stable, so each word is presented for 2 cycles.
  - Next state: if addr==N-1, go to TAIL; otherwise addr++ and return to LOAD.
- TAIL:
  - Flag stays high for this one cycle.
  - Next cycle: flag=0, oNumOfCoeff<=N, oDone pulses, go to IDLE.
- Abort:
  - iUpdAbort in LOAD or HOLD: go to IDLE next cycle with flag=0 and an oErr pulse. oNumOfCoeff is unchanged.
  - If iUpdAbort and iCoefValid are both high in LOAD, the abort wins and the word is not accepted.
  - iUpdAbort in IDLE or TAIL is ignored.
- iUpdReq outside IDLE is ignored. It does not raise an error.
- oAddrRam and oWrDtRam hold their last values outside writes.
- Width rules: addr compared as ADDR_W unsigned. N=MAX_COEFF is legal. iUpdNum=63 is rejected.
- Reset during an update: immediate return to IDLE. Flag drops asynchronously and oNumOfCoeff returns to MAX_COEFF.

Decomposition:
- fir_ctrl_pkg holds:
  - the state enum (IDLE/LOAD/HOLD/TAIL);
  - the CLK_DIV, MAX_COEFF, ADDR_W and DATA_W defaults;
  - a function for the legal-count check.
- One sub-module, fir_sample_strobe_gen: the divider counter plus the gate input. It outputs oEnSample600k.

Test Plan:
- Reset release, idle for 100 cycles -> strobes at cycles 20, 40, 60, 80, 100; each strobe 1 cycle wide; flag stays 0.
- iUpdNum=40, host sends data k+1 for k=0..39 back-to-back -> addr 0..39 each held 2 cycles with data k+1; flag high for exactly 81 cycles; oNumOfCoeff=40; one oDone pulse; no strobes while the flag is high.
- iCoefValid toggled 1-of-3 cycles during an iUpdNum=4 update -> exactly 4 writes in order, no duplicates, no skipped addresses; strobes resume at the next counter wrap after the flag drops.
- iUpdNum=0, then iUpdNum=41 -> oErr pulses twice, FSM never leaves IDLE, oNumOfCoeff stays 40.
- Abort after 10 of 20 words, with iCoefValid high in the same cycle -> the 11th word is not written, flag drops, oErr pulses, oNumOfCoeff unchanged.
- iRsn asserted mid-update at addr 5 -> all outputs go to reset values immediately; after release, a fresh 3-tap update completes normally.
